// File: rtl/airi5c_ahb_dmem_slave.sv
// AHB-Lite data-memory responder for the AIRI5C core.
// Word-organised RAM, configurable wait states, two-cycle ERROR response.
module airi5c_ahb_dmem_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 256,
    parameter int          WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [1:0]  htrans,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic [31:0] hrdata,
    output logic        hreadyout,
    output logic        hresp
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t        state_q;
    logic [3:0]    cnt_q;
    logic [AW+1:0] off_q;
    logic          write_q;
    logic [1:0]    size_q;
    logic          pend_q;

    logic [31:0]   mem_q [DEPTH_WORDS];

    logic [31:0]   offset;
    logic          err;
    logic          accept;
    logic          done;
    logic [AW-1:0] idx;
    logic [3:0]    be;

    assign offset = haddr - BASE_ADDR;

    assign err = (offset >= 32'(DEPTH_WORDS * 4))
               | (hsize > 3'd2)
               | ((hsize == 3'd1) & haddr[0])
               | ((hsize == 3'd2) & (haddr[1:0] != 2'b00));

    assign accept = hsel & hready & hreadyout
                  & ((htrans == 2'b10) | (htrans == 2'b11));

    // An OKAY data phase completes in the first ready cycle after its
    // address phase (zero-wait) or after the wait countdown expires.
    assign done = (state_q == S_IDLE) & pend_q;
    assign idx  = off_q[AW+1:2];

    always_comb begin
        hreadyout = 1'b1;
        hresp     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                hreadyout = 1'b1;
                hresp     = 1'b0;
            end
            S_WAIT: begin
                hreadyout = 1'b0;
                hresp     = 1'b0;
            end
            S_ERR1: begin
                hreadyout = 1'b0;
                hresp     = 1'b1;
            end
            S_ERR2: begin
                hreadyout = 1'b1;
                hresp     = 1'b1;
            end
            default: begin
                hreadyout = 1'b1;
                hresp     = 1'b0;
            end
        endcase
    end

    assign hrdata = (done & ~write_q) ? mem_q[idx] : 32'h0;

    always_comb begin
        be = 4'h0;
        unique case (size_q)
            2'd0:    be[off_q[1:0]] = 1'b1;
            2'd1:    be[{off_q[1], 1'b0} +: 2] = 2'b11;
            default: be = 4'hF;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            off_q   <= '0;
            write_q <= 1'b0;
            size_q  <= 2'd0;
            pend_q  <= 1'b0;
        end else begin
            pend_q <= 1'b0;
            unique case (state_q)
                S_IDLE, S_ERR2: begin
                    state_q <= S_IDLE;
                    if (accept) begin
                        off_q   <= offset[AW+1:0];
                        write_q <= hwrite;
                        size_q  <= hsize[1:0];
                        if (err) begin
                            state_q <= S_ERR1;
                        end else if (WAIT_STATES == 0) begin
                            pend_q <= 1'b1;
                        end else begin
                            state_q <= S_WAIT;
                            cnt_q   <= 4'(WAIT_STATES);
                        end
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= S_IDLE;
                        pend_q  <= 1'b1;
                    end
                end
                S_ERR1: state_q <= S_ERR2;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Writes commit only on the completing edge, so an abandoned or
    // errored transfer can never touch the array.
    always_ff @(posedge clk) begin
        if (done & write_q) begin
            for (int n = 0; n < 4; n++) begin
                if (be[n]) begin
                    mem_q[idx][8*n +: 8] <= hwdata[8*n +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_airi5c_ahb_dmem_slave.sv
// Scoreboard bench for airi5c_ahb_dmem_slave.
// Three instances cover zero, two and three wait states.
module tb_airi5c_ahb_dmem_slave;

    localparam logic [31:0] B = 32'h8000_0000;

    typedef struct {
        logic [31:0] rdata;
        logic        resp;
        int          waits;
    } exp_t;

    logic        clk = 1'b0;
    logic        nreset;
    logic        hsel;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
    logic [31:0] hwdata;
    logic        hrdy_en;
    int          sel;

    logic [31:0] rd [3];
    logic        ro [3];
    logic        rp [3];

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   done_cyc = 0;
    int   t0;
    bit   active = 0;
    int   waits;
    bit   bad;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    airi5c_ahb_dmem_slave #(.WAIT_STATES(0)) u0 (
        .clk(clk), .nreset(nreset), .hsel(hsel && sel == 0),
        .haddr(haddr), .hwrite(hwrite), .hsize(hsize),
        .htrans(htrans), .hwdata(hwdata), .hready(hrdy_en & ro[0]),
        .hrdata(rd[0]), .hreadyout(ro[0]), .hresp(rp[0])
    );

    airi5c_ahb_dmem_slave #(.WAIT_STATES(3)) u1 (
        .clk(clk), .nreset(nreset), .hsel(hsel && sel == 1),
        .haddr(haddr), .hwrite(hwrite), .hsize(hsize),
        .htrans(htrans), .hwdata(hwdata), .hready(hrdy_en & ro[1]),
        .hrdata(rd[1]), .hreadyout(ro[1]), .hresp(rp[1])
    );

    airi5c_ahb_dmem_slave #(.WAIT_STATES(2)) u2 (
        .clk(clk), .nreset(nreset), .hsel(hsel && sel == 2),
        .haddr(haddr), .hwrite(hwrite), .hsize(hsize),
        .htrans(htrans), .hwdata(hwdata), .hready(hrdy_en & ro[2]),
        .hrdata(rd[2]), .hreadyout(ro[2]), .hresp(rp[2])
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int ws_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 3 : 2);
    endfunction

    // Monitor: times each data phase and compares at its completion.
    always @(negedge clk) begin
        if (!nreset) begin
            if (active && q.size() > 0) void'(q.pop_front());
            active = 0;
        end else begin
            if (active) begin
                if (!ro[sel]) begin
                    waits++;
                    if (q.size() == 0 || rp[sel] !== q[0].resp ||
                        rd[sel] !== 32'h0)
                        bad = 1;
                end else if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected completion: no entry queued");
                    active = 0;
                end else begin
                    e = q.pop_front();
                    chk("rdata", rd[sel], e.rdata);
                    chk("hresp", 32'(rp[sel]), 32'(e.resp));
                    chk("waits", waits, e.waits);
                    chk("wait-cycle outputs", 32'(bad), 32'd0);
                    done_cyc = cyc + 1;
                    active = 0;
                end
            end
            if (hsel && htrans[1] && hrdy_en && ro[sel]) begin
                active = 1;
                waits = 0;
                bad = 0;
            end
        end
    end

    task automatic xfer(input int k, input bit wr, input logic [2:0] sz,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input bit exp_err);
        exp_t x;
        int n;
        x.rdata = (wr || exp_err) ? 32'h0 : exp_rd;
        x.resp  = exp_err;
        x.waits = exp_err ? 1 : ws_of(k);
        q.push_back(x);
        sel = k;
        hsel = 1'b1;
        htrans = 2'b10;
        hwrite = wr;
        hsize = sz;
        haddr = a;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(hrdy_en && ro[sel]) && n < 50);
        if (n >= 50) chk("accept timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1;
        hsel = 1'b0;
        htrans = 2'b00;
        if (wr) hwdata = wd;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || active) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        nreset = 1'b0;
        #1;
        chk("rst hreadyout", 32'(ro[sel]), 32'd1);
        chk("rst hresp", 32'(rp[sel]), 32'd0);
        chk("rst hrdata", rd[sel], 32'h0);
        @(posedge clk);
        #1;
        nreset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        nreset = 1'b0;
        hsel = 1'b0;
        haddr = 32'h0;
        hwrite = 1'b0;
        hsize = 3'd0;
        htrans = 2'b00;
        hwdata = 32'h0;
        hrdy_en = 1'b1;
        sel = 0;
        repeat (2) @(posedge clk);
        #1;
        nreset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("reset hreadyout", 32'(ro[i]), 32'd1);
            chk("reset hresp", 32'(rp[i]), 32'd0);
            chk("reset hrdata", rd[i], 32'h0);
        end
        @(posedge clk);
        #1;

        // Zero-wait pipelined write then read
        xfer(0, 1, 3'd2, B + 32'h10, 32'hDEAD_BEEF, 32'h0, 0);
        xfer(0, 0, 3'd2, B + 32'h10, 32'h0, 32'hDEAD_BEEF, 0);
        drain();

        // Reset while read data is on the bus
        xfer(0, 0, 3'd2, B + 32'h10, 32'h0, 32'hDEAD_BEEF, 0);
        chk("pre-reset hrdata", rd[0], 32'hDEAD_BEEF);
        pulse_reset();

        // Reset during ERR1
        xfer(0, 1, 3'd2, B + 32'h2, 32'h0, 32'h0, 1);
        chk("err1 hreadyout", 32'(ro[0]), 32'd0);
        chk("err1 hresp", 32'(rp[0]), 32'd1);
        pulse_reset();
        xfer(0, 0, 3'd2, B + 32'h10, 32'h0, 32'hDEAD_BEEF, 0);
        drain();

        // Byte and halfword lanes
        xfer(0, 1, 3'd2, B + 32'h20, 32'h0, 32'h0, 0);
        xfer(0, 1, 3'd0, B + 32'h23, 32'hAA00_0000, 32'h0, 0);
        xfer(0, 1, 3'd1, B + 32'h20, 32'h0000_1234, 32'h0, 0);
        xfer(0, 0, 3'd2, B + 32'h20, 32'h0, 32'hAA00_1234, 0);
        drain();

        // Three wait states, pipelined pair
        xfer(1, 1, 3'd2, B + 32'h40, 32'h0BAD_C0DE, 32'h0, 0);
        t0 = cyc;
        xfer(1, 0, 3'd2, B + 32'h40, 32'h0, 32'h0BAD_C0DE, 0);
        drain();
        chk("two-transfer cycles", done_cyc - t0, 32'd8);

        // Error responses leave RAM untouched
        xfer(0, 1, 3'd2, B, 32'hCAFE_F00D, 32'h0, 0);
        xfer(0, 1, 3'd2, B + 32'h400, 32'h0, 32'h0, 1);
        xfer(0, 1, 3'd2, B + 32'h2, 32'hFFFF_FFFF, 32'h0, 1);
        xfer(0, 1, 3'd1, B + 32'h1, 32'hFFFF_FFFF, 32'h0, 1);
        xfer(0, 0, 3'd1, B + 32'h1, 32'h0, 32'h0, 1);
        xfer(0, 1, 3'd3, B, 32'hFFFF_FFFF, 32'h0, 1);
        xfer(0, 0, 3'd2, B + 32'h400, 32'h0, 32'h0, 1);
        xfer(0, 0, 3'd2, B, 32'h0, 32'hCAFE_F00D, 0);
        drain();

        // Non-transfers and hready low
        hwdata = 32'h0;
        hwrite = 1'b1;
        hsize = 3'd2;
        haddr = B;
        hsel = 1'b1;
        htrans = 2'b00;
        @(posedge clk);
        #1;
        chk("idle hreadyout", 32'(ro[0]), 32'd1);
        chk("idle hresp", 32'(rp[0]), 32'd0);
        htrans = 2'b01;
        @(posedge clk);
        #1;
        chk("busy hreadyout", 32'(ro[0]), 32'd1);
        chk("busy hresp", 32'(rp[0]), 32'd0);
        hsel = 1'b0;
        htrans = 2'b10;
        @(posedge clk);
        #1;
        chk("nosel hreadyout", 32'(ro[0]), 32'd1);
        chk("nosel hresp", 32'(rp[0]), 32'd0);
        hrdy_en = 1'b0;
        hsel = 1'b1;
        hwrite = 1'b0;
        @(posedge clk);
        #1;
        hsel = 1'b0;
        htrans = 2'b00;
        hrdy_en = 1'b1;
        chk("blocked hrdata", rd[0], 32'h0);
        chk("blocked hreadyout", 32'(ro[0]), 32'd1);
        xfer(0, 0, 3'd2, B, 32'h0, 32'hCAFE_F00D, 0);
        drain();

        // Reset during WAIT abandons the write
        xfer(2, 1, 3'd2, B + 32'h80, 32'h1111_1111, 32'h0, 0);
        drain();
        xfer(2, 1, 3'd2, B + 32'h80, 32'h5555_5555, 32'h0, 0);
        chk("wait hreadyout", 32'(ro[2]), 32'd0);
        pulse_reset();
        xfer(2, 0, 3'd2, B + 32'h80, 32'h0, 32'h1111_1111, 0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
